// File: rtl/tuple_table_report_engine_if.sv
// Bundle of the RAM read-request side and the report stream of the tuple table report engine.
// The engine takes the master view; the arbiter/RAM and the controller take the slave view.
interface tuple_table_report_engine_if #(
    parameter int DATA_W = 152,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] ov_ram_raddr;
    logic              o_ram_rd;
    logic [DATA_W-1:0] iv_ram_rdata;
    logic              i_rw_conflict;
    logic              i_report_start;
    logic [ADDR_W-1:0] ov_report_addr;
    logic [DATA_W-1:0] ov_report_data;
    logic              o_report_valid;
    logic              i_report_ready;
    logic              o_busy;
    logic              o_report_done;
    logic              o_report_error;

    modport master (
        input  iv_ram_rdata, i_rw_conflict, i_report_start, i_report_ready,
        output ov_ram_raddr, o_ram_rd, ov_report_addr, ov_report_data,
               o_report_valid, o_busy, o_report_done, o_report_error
    );

    modport slave (
        output iv_ram_rdata, i_rw_conflict, i_report_start, i_report_ready,
        input  ov_ram_raddr, o_ram_rd, ov_report_addr, ov_report_data,
               o_report_valid, o_busy, o_report_done, o_report_error
    );
endinterface

// File: rtl/tuple_table_report_engine.sv
// Sweeps the 5-tuple mapping table one read at a time, retrying reads dropped by the arbiter,
// and streams each returned entry to the controller over a ready/valid report port.
module tuple_table_report_engine #(
    parameter int DATA_W    = 152,
    parameter int ADDR_W    = 5,
    parameter int DEPTH     = 32,
    parameter int RD_LAT    = 3,
    parameter int MAX_RETRY = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    tuple_table_report_engine_if.master bus
);
    localparam int WCNT_W  = $clog2(RD_LAT + 1);
    localparam int RETRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        OUTPUT = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [RETRY_W-1:0]  retry_r, retry_s;
    logic [WCNT_W-1:0]   wcnt_r, wcnt_s;
    logic                error_r, error_s;
    logic [ADDR_W-1:0]   rep_addr_r, rep_addr_s;
    logic [DATA_W-1:0]   rep_data_r, rep_data_s;
    logic                ram_rd_r;
    logic [ADDR_W-1:0]   ram_raddr_r;
    logic                valid_r;
    logic                busy_r;
    logic                done_r;

    // Next-state and next-register logic; all outputs are registered from these values.
    always_comb begin
        state_s    = state_r;
        addr_s     = addr_r;
        retry_s    = retry_r;
        wcnt_s     = wcnt_r;
        error_s    = error_r;
        rep_addr_s = rep_addr_r;
        rep_data_s = rep_data_r;
        case (state_r)
            IDLE: begin
                if (bus.i_report_start) begin
                    addr_s  = {ADDR_W{1'b0}};
                    retry_s = {RETRY_W{1'b0}};
                    error_s = 1'b0;
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                wcnt_s  = {WCNT_W{1'b0}};
                state_s = WAIT;
            end
            WAIT: begin
                // The last WAIT cycle is the one where the arbiter presents data and conflict.
                if (wcnt_r == WCNT_W'(RD_LAT - 1)) begin
                    if (!bus.i_rw_conflict) begin
                        rep_data_s = bus.iv_ram_rdata;
                        rep_addr_s = addr_r;
                        retry_s    = {RETRY_W{1'b0}};
                        state_s    = OUTPUT;
                    end else if (retry_r == RETRY_W'(MAX_RETRY - 1)) begin
                        error_s = 1'b1;
                        state_s = DONE;
                    end else begin
                        retry_s = retry_r + RETRY_W'(1);
                        state_s = ISSUE;
                    end
                end else begin
                    wcnt_s = wcnt_r + WCNT_W'(1);
                end
            end
            OUTPUT: begin
                if (bus.i_report_ready) begin
                    if (addr_r == ADDR_W'(DEPTH - 1)) begin
                        state_s = DONE;
                    end else begin
                        addr_s  = addr_r + ADDR_W'(1);
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = OUTPUT;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset aborts any sweep without a done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r     <= IDLE;
            addr_r      <= {ADDR_W{1'b0}};
            retry_r     <= {RETRY_W{1'b0}};
            wcnt_r      <= {WCNT_W{1'b0}};
            error_r     <= 1'b0;
            rep_addr_r  <= {ADDR_W{1'b0}};
            rep_data_r  <= {DATA_W{1'b0}};
            ram_rd_r    <= 1'b0;
            ram_raddr_r <= {ADDR_W{1'b0}};
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            addr_r      <= addr_s;
            retry_r     <= retry_s;
            wcnt_r      <= wcnt_s;
            error_r     <= error_s;
            rep_addr_r  <= rep_addr_s;
            rep_data_r  <= rep_data_s;
            ram_rd_r    <= (state_s == ISSUE);
            ram_raddr_r <= addr_s;
            valid_r     <= (state_s == OUTPUT);
            busy_r      <= (state_s == ISSUE) || (state_s == WAIT) || (state_s == OUTPUT);
            done_r      <= (state_s == DONE);
        end
    end

    assign bus.o_ram_rd       = ram_rd_r;
    assign bus.ov_ram_raddr   = ram_raddr_r;
    assign bus.ov_report_addr = rep_addr_r;
    assign bus.ov_report_data = rep_data_r;
    assign bus.o_report_valid = valid_r;
    assign bus.o_busy         = busy_r;
    assign bus.o_report_done  = done_r;
    assign bus.o_report_error = error_r;
endmodule

// File: tb/tb_tuple_table_report_engine.sv
// Directed bench for tuple_table_report_engine: a 3-cycle-latency RAM/arbiter model with
// scripted conflicts, a negedge monitor logging traffic, and hand-derived expected values.
module tb_tuple_table_report_engine;
    localparam int DATA_W = 152;
    localparam int ADDR_W = 5;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    tuple_table_report_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    tuple_table_report_engine #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(32), .RD_LAT(3), .MAX_RETRY(4)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [DATA_W-1:0] ram_word(input int a);
        logic [DATA_W-1:0] w;
        w = '0;
        w[15:0] = 16'(a * 3);
        w[DATA_W-1 -: 8] = 8'(a) ^ 8'hA5;
        return w;
    endfunction

    // RAM/arbiter model: 3-stage pipeline from o_ram_rd to data/conflict.
    logic [2:0]        pv = 3'b000;
    logic [ADDR_W-1:0] pa [3];
    logic [2:0]        pc = 3'b000;
    int                conf_addr = -1;
    int                conf_n = 0;
    int                hit = 0;
    logic              conf_now;

    assign conf_now = bus.o_ram_rd && (int'(bus.ov_ram_raddr) == conf_addr) && (hit < conf_n);

    always @(posedge clk) begin
        pv    <= {pv[1:0], bus.o_ram_rd};
        pc    <= {pc[1:0], conf_now};
        pa[0] <= bus.ov_ram_raddr;
        pa[1] <= pa[0];
        pa[2] <= pa[1];
        cyc   <= cyc + 1;
        if (bus.i_report_start) hit <= 0;
        else if (conf_now) hit <= hit + 1;
    end

    assign bus.iv_ram_rdata  = pv[2] ? ram_word(int'(pa[2])) : {DATA_W{1'b1}};
    assign bus.i_rw_conflict = pv[2] ? pc[2] : 1'b1;

    // Monitor logs
    int                wa_q [$];
    logic [DATA_W-1:0] wd_q [$];
    int                ra_q [$];
    int                rc_q [$];
    int                done_q [$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_report_valid && bus.i_report_ready) begin
                wa_q.push_back(int'(bus.ov_report_addr));
                wd_q.push_back(bus.ov_report_data);
            end
            if (bus.o_ram_rd) begin
                ra_q.push_back(int'(bus.ov_ram_raddr));
                rc_q.push_back(cyc);
            end
            if (bus.o_report_done) done_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wa_q.delete(); wd_q.delete(); ra_q.delete(); rc_q.delete(); done_q.delete();
    endtask

    task automatic pulse_start();
        bus.i_report_start = 1'b1;
        tick();
        bus.i_report_start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && done_q.size() == 0; i++) tick();
        check("done_seen", done_q.size() != 0, 1);
        repeat (3) tick();
        check("done_once", done_q.size(), 1);
        check("busy_after", bus.o_busy, 0);
    endtask

    task automatic check_words(input int n);
        check("word_count", wa_q.size(), n);
        for (int i = 0; i < n && i < wa_q.size(); i++) begin
            check("word_addr", wa_q[i], i);
            check("word_data", wd_q[i], ram_word(i));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ram_rd"}, bus.o_ram_rd, 0);
        check({tag, "_raddr"}, bus.ov_ram_raddr, 0);
        check({tag, "_valid"}, bus.o_report_valid, 0);
        check({tag, "_raddr_rep"}, bus.ov_report_addr, 0);
        check({tag, "_rdata_rep"}, bus.ov_report_data, 0);
        check({tag, "_busy"}, bus.o_busy, 0);
        check({tag, "_done"}, bus.o_report_done, 0);
        check({tag, "_error"}, bus.o_report_error, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.i_report_start = 1'b0;
        bus.i_report_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check_idle_outputs("reset");

        // 1: clean sweep, ready high
        bus.i_report_ready = 1'b1;
        clear_logs();
        pulse_start();
        check("busy_start", bus.o_busy, 1);
        check("rd_first", bus.o_ram_rd, 1);
        wait_done(400);
        check_words(32);
        check("error_clean", bus.o_report_error, 0);
        check("rd_count_clean", ra_q.size(), 32);
        if (rc_q.size() > 1) check("throughput", rc_q[1] - rc_q[0], 5);
        else check("throughput_log", rc_q.size(), 2);

        // 2: single conflict at address 5
        clear_logs();
        conf_addr = 5; conf_n = 1;
        pulse_start();
        wait_done(400);
        check_words(32);
        check("rd_count_retry", ra_q.size(), 33);
        if (ra_q.size() > 6) begin
            check("retry_addr_a", ra_q[5], 5);
            check("retry_addr_b", ra_q[6], 5);
            check("retry_gap", rc_q[6] - rc_q[5], 4);
        end else check("retry_log", ra_q.size(), 33);
        check("error_retry", bus.o_report_error, 0);

        // 3: retry exhaustion at address 9
        clear_logs();
        conf_addr = 9; conf_n = 4;
        pulse_start();
        wait_done(400);
        check_words(9);
        check("rd_count_abort", ra_q.size(), 13);
        check("error_abort", bus.o_report_error, 1);
        conf_addr = -1; conf_n = 0;
        clear_logs();
        pulse_start();
        check("error_cleared", bus.o_report_error, 0);
        wait_done(400);
        check_words(32);
        check("error_after", bus.o_report_error, 0);

        // 4+5: manual handshake; stall on word 2, stray start on word 7
        clear_logs();
        bus.i_report_ready = 1'b0;
        pulse_start();
        for (int w = 0; w < 32; w++) begin
            for (int i = 0; i < 50 && !bus.o_report_valid; i++) tick();
            check("valid_wait", bus.o_report_valid, 1);
            if (w == 2) begin
                for (int i = 0; i < 10; i++) begin
                    tick();
                    check("stall_valid", bus.o_report_valid, 1);
                    check("stall_addr", bus.ov_report_addr, 2);
                    check("stall_data", bus.ov_report_data, ram_word(2));
                end
                check("stall_no_rd", ra_q.size(), 3);
            end
            if (w == 7) begin
                pulse_start();
                check("stray_busy", bus.o_busy, 1);
            end
            bus.i_report_ready = 1'b1;
            tick();
            bus.i_report_ready = 1'b0;
        end
        wait_done(50);
        check_words(32);
        check("error_manual", bus.o_report_error, 0);

        // 6: reset while waiting on address 12
        bus.i_report_ready = 1'b1;
        clear_logs();
        pulse_start();
        for (int i = 0; i < 200 && !(bus.o_ram_rd && bus.ov_ram_raddr == 5'd12); i++) tick();
        check("reach_12", bus.o_ram_rd && bus.ov_ram_raddr == 5'd12, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_outputs("midrst");
        repeat (6) tick();
        check("midrst_no_done", done_q.size(), 0);
        check("midrst_idle", bus.o_busy, 0);
        check("midrst_words", wa_q.size(), 12);
        clear_logs();
        pulse_start();
        wait_done(400);
        check_words(32);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
